// File: rtl/power_pkg.sv
// Shared constants for the square-and-multiply power unit and the operation mux.
package power_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_RWIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/power_mul_ovf.sv
// Unsigned RWIDTH x RWIDTH multiplier returning the truncated product and a flag
// telling whether any bit of the discarded high half is set.
module power_mul_ovf #(
    parameter int RWIDTH = power_pkg::DEF_RWIDTH
) (
    input  logic [RWIDTH-1:0] a,
    input  logic [RWIDTH-1:0] b,
    output logic [RWIDTH-1:0] lo,
    output logic              hi_nz
);

    logic [2*RWIDTH-1:0] full;

    always_comb begin
        full  = {{RWIDTH{1'b0}}, a} * {{RWIDTH{1'b0}}, b};
        lo    = full[RWIDTH-1:0];
        hi_nz = |full[2*RWIDTH-1:RWIDTH];
    end

endmodule

// File: rtl/power_sqm.sv
// Sign-magnitude base raised to an unsigned exponent by right-to-left
// square-and-multiply, with start/busy/done handshake, abort and exact overflow.
module power_sqm
    import power_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RWIDTH = DEF_RWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  base_mag,
    input  logic              base_sign,
    input  logic [WIDTH-1:0]  exp,
    output logic              busy,
    output logic              done,
    output logic [RWIDTH-1:0] result,
    output logic              result_sign,
    output logic              overflow
);

    logic [1:0]        state_q, state_d;
    logic [RWIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0]  e_q, e_d;
    logic [RWIDTH-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              bovf_q, bovf_d;
    logic              sgn_q, sgn_d;
    logic [RWIDTH-1:0] result_q, result_d;
    logic              result_sign_q, result_sign_d;
    logic              overflow_q, overflow_d;

    logic [RWIDTH-1:0] acc_lo, sq_lo;
    logic              acc_hi, sq_hi;

    power_mul_ovf #(.RWIDTH(RWIDTH)) u_acc_mul (
        .a     (acc_q),
        .b     (b_q),
        .lo    (acc_lo),
        .hi_nz (acc_hi)
    );

    power_mul_ovf #(.RWIDTH(RWIDTH)) u_sq_mul (
        .a     (b_q),
        .b     (b_q),
        .lo    (sq_lo),
        .hi_nz (sq_hi)
    );

    always_comb begin
        state_d       = state_q;
        b_d           = b_q;
        e_d           = e_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        bovf_d        = bovf_q;
        sgn_d         = sgn_q;
        result_d      = result_q;
        result_sign_d = result_sign_q;
        overflow_d    = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    b_d     = RWIDTH'(base_mag);
                    e_d     = exp;
                    acc_d   = RWIDTH'(1);
                    ovf_d   = 1'b0;
                    bovf_d  = 1'b0;
                    sgn_d   = base_sign & exp[0];
                    state_d = (exp == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // A squared term that overflowed only matters once it is folded in.
                if (e_q[0]) begin
                    acc_d = acc_lo;
                    ovf_d = ovf_q | acc_hi | bovf_q;
                end
                b_d    = sq_lo;
                bovf_d = bovf_q | sq_hi;
                e_d    = e_q >> 1;
                if (e_d == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Load outputs on entry to DONE so they are valid alongside the done pulse.
        if (state_d == ST_DONE) begin
            result_d      = acc_d;
            overflow_d    = ovf_d;
            result_sign_d = sgn_d & (acc_d != '0);
        end

        if (abort) begin
            state_d       = ST_IDLE;
            result_d      = '0;
            result_sign_d = 1'b0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            b_q           <= '0;
            e_q           <= '0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            bovf_q        <= 1'b0;
            sgn_q         <= 1'b0;
            result_q      <= '0;
            result_sign_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            b_q           <= b_d;
            e_q           <= e_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            bovf_q        <= bovf_d;
            sgn_q         <= sgn_d;
            result_q      <= result_d;
            result_sign_q <= result_sign_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE) & ~abort;
    assign result      = result_q;
    assign result_sign = result_sign_q;
    assign overflow    = overflow_q;

endmodule
